// File: rtl/par_host_8bit_if.sv
// par_host_8bit_if: local request/response and peripheral strobe/ack signals of the parallel host
interface par_host_8bit_if;
  logic       req, rw, ack, busy, done, err, w_r, stb;
  logic [7:0] wdata, rdata;
  modport master (input req, rw, wdata, ack, output rdata, busy, done, err, w_r, stb);
  modport slave (output req, rw, wdata, ack, input rdata, busy, done, err, w_r, stb);
endinterface

// File: rtl/par_host_8bit.sv
// par_host_8bit: 8-bit strobe/ack parallel bus host with per-edge ack timeout
module par_host_8bit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  par_host_8bit_if.master bus,
  inout  wire  [7:0]      pbus
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, RELEASE = 2'd3;
  logic [1:0] r_state, w_next;
  logic       r_rw, r_done, r_err, w_wait, w_timeout, w_busy, w_w_r;
  logic [7:0] r_wdata, r_rdata, r_cnt;
  assign w_wait    = (r_state == STROBE) ? !bus.ack : (r_state == RELEASE) ? bus.ack : 1'b0;
  assign w_timeout = w_wait && (r_cnt == 8'(TIMEOUT - 1));
  assign w_busy    = r_state != IDLE;
  assign w_w_r     = w_busy && r_rw;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.req ? SETUP : IDLE;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = w_timeout ? IDLE : w_wait ? STROBE : RELEASE;
      default: w_next = (w_wait && !w_timeout) ? RELEASE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == RELEASE) && !bus.ack;
      r_err   <= w_timeout;
      r_cnt   <= (w_next != r_state) ? '0 : w_wait ? r_cnt + 8'd1 : r_cnt;
      if (r_state == IDLE && bus.req) begin
        r_rw    <= bus.rw;
        r_wdata <= bus.wdata;
      end
      if (r_state == STROBE && bus.ack && !r_rw) r_rdata <= pbus;
    end
  assign bus.busy  = w_busy;
  assign bus.stb   = r_state == STROBE;
  assign bus.w_r   = w_w_r;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
  assign pbus      = w_w_r ? r_wdata : 8'hzz;
endmodule

// File: tb/tb_par_host_8bit.sv
// tb_par_host_8bit: directed transactions with a response scoreboard and bus monitor
module tb_par_host_8bit;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  par_host_8bit_if bus();
  wire  [7:0] pbus;
  logic       p_oe = 1'b0;
  logic [7:0] p_dat = 8'h00;
  assign pbus = p_oe ? p_dat : 8'hzz;
  par_host_8bit #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus), .pbus(pbus));
  typedef struct packed {logic is_err; logic [7:0] rdata;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  logic [7:0] exp_w = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  always @(negedge clk) if (rst) begin
    exp_t e;
    if (bus.done || bus.err) begin
      chk("done_err_exclusive", {31'd0, bus.done & bus.err}, 32'd0);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response: done=%0b err=%0b rdata=%0h", bus.done, bus.err, bus.rdata);
      end else begin
        e = q.pop_front();
        chk("resp_kind_err", {31'd0, bus.err}, {31'd0, e.is_err});
        chk("resp_rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
      end
    end
    if (bus.w_r) chk("pbus_write_data", {24'd0, pbus}, {24'd0, exp_w});
  end
  task automatic wait_stb(input string name, input logic lvl);
    int n = 0;
    while (bus.stb !== lvl && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.stb !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: stb stuck at %0b, wanted %0b", name, bus.stb, lvl);
    end
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s: busy stuck at %0b, wanted 0", name, bus.busy);
    end
  endtask
  task automatic start(input logic rw, input logic [7:0] wd);
    bus.req = 1'b1;
    bus.rw = rw;
    bus.wdata = wd;
    exp_w = wd;
    @(negedge clk);
    bus.req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.req = 1'b0; bus.rw = 1'b0; bus.wdata = 8'h00; bus.ack = 1'b0;
    #3 rst = 1'b0;
    #9;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_stb", {31'd0, bus.stb}, 0);
    chk("rst_w_r", {31'd0, bus.w_r}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_rdata", {24'd0, bus.rdata}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.push_back('{1'b0, 8'h00});
    start(1'b1, 8'hA5);
    wait_stb("wr_stb", 1'b1);
    repeat (2) @(negedge clk);
    bus.ack = 1'b1;
    wait_stb("wr_rel", 1'b0);
    chk("wr_release_w_r", {31'd0, bus.w_r}, 1);
    @(negedge clk);
    bus.ack = 1'b0;
    wait_idle("wr_idle");
    chk("wr_rdata_kept", {24'd0, bus.rdata}, 0);
    @(negedge clk);
    q.push_back('{1'b0, 8'h3C});
    p_dat = 8'h3C; p_oe = 1'b1; bus.ack = 1'b1;
    bus.req = 1'b1; bus.rw = 1'b0;
    @(negedge clk);
    bus.req = 1'b0;
    chk("rd_setup_stb", {31'd0, bus.stb}, 0);
    chk("rd_setup_busy", {31'd0, bus.busy}, 1);
    chk("rd_setup_w_r", {31'd0, bus.w_r}, 0);
    @(negedge clk);
    chk("rd_strobe_stb", {31'd0, bus.stb}, 1);
    chk("rd_strobe_pbus", {24'd0, pbus}, 32'h3C);
    @(negedge clk);
    chk("rd_release_stb", {31'd0, bus.stb}, 0);
    chk("rd_release_busy", {31'd0, bus.busy}, 1);
    bus.ack = 1'b0;
    @(negedge clk);
    chk("rd_latency_done", {31'd0, bus.done}, 1);
    p_oe = 1'b0;
    chk("rd_rdata", {24'd0, bus.rdata}, 32'h3C);
    @(negedge clk);
    q.push_back('{1'b1, 8'h3C});
    start(1'b0, 8'h00);
    wait_stb("to_stb", 1'b1);
    n = 0;
    while (bus.stb && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_strobe_cycles", n, 15);
    chk("to_stb_low", {31'd0, bus.stb}, 0);
    chk("to_w_r_low", {31'd0, bus.w_r}, 0);
    chk("to_busy_low", {31'd0, bus.busy}, 0);
    chk("to_rdata_kept", {24'd0, bus.rdata}, 32'h3C);
    @(negedge clk);
    q.push_back('{1'b1, 8'h77});
    p_dat = 8'h77; p_oe = 1'b1; bus.ack = 1'b1;
    start(1'b0, 8'h00);
    wait_stb("rt_stb", 1'b1);
    wait_stb("rt_rel", 1'b0);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("rt_release_cycles", n, 15);
    chk("rt_rdata_captured", {24'd0, bus.rdata}, 32'h77);
    bus.ack = 1'b0; p_oe = 1'b0;
    @(negedge clk);
    start(1'b1, 8'h55);
    wait_stb("rs_stb", 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("rs_async_stb", {31'd0, bus.stb}, 0);
    chk("rs_async_w_r", {31'd0, bus.w_r}, 0);
    chk("rs_async_busy", {31'd0, bus.busy}, 0);
    chk("rs_async_rdata", {24'd0, bus.rdata}, 0);
    @(negedge clk);
    chk("rs_no_done", {31'd0, bus.done}, 0);
    chk("rs_no_err", {31'd0, bus.err}, 0);
    rst = 1'b1;
    @(negedge clk);
    q.push_back('{1'b0, 8'h00});
    start(1'b1, 8'h11);
    wait_stb("rs2_stb", 1'b1);
    bus.ack = 1'b1;
    wait_stb("rs2_rel", 1'b0);
    bus.ack = 1'b0;
    wait_idle("rs2_idle");
    @(negedge clk);
    q.push_back('{1'b0, 8'h00});
    q.push_back('{1'b0, 8'hFE});
    exp_w = 8'h01;
    bus.req = 1'b1; bus.rw = 1'b1; bus.wdata = 8'h01;
    wait_stb("bb_stb1", 1'b1);
    bus.rw = 1'b0; bus.wdata = 8'hEE;
    bus.ack = 1'b1;
    wait_stb("bb_rel1", 1'b0);
    bus.ack = 1'b0;
    wait_idle("bb_done1");
    @(negedge clk);
    bus.req = 1'b0;
    chk("bb_restart_busy", {31'd0, bus.busy}, 1);
    chk("bb_read_w_r", {31'd0, bus.w_r}, 0);
    p_dat = 8'hFE; p_oe = 1'b1;
    wait_stb("bb_stb2", 1'b1);
    bus.ack = 1'b1;
    wait_stb("bb_rel2", 1'b0);
    bus.ack = 1'b0;
    wait_idle("bb_done2");
    p_oe = 1'b0;
    chk("bb_rdata", {24'd0, bus.rdata}, 32'hFE);
    repeat (4) @(negedge clk);
    chk("bb_no_restart", {31'd0, bus.busy}, 0);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
